// File: rtl/pixel_line_capture_if.sv
// Raster receive bundle for pixel_line_capture.
// Carries the source-side raster signals (HSYNC, VSYNC, Pixel_DATA) and the
// frame-buffer write / status outputs. The capture block takes the slave
// modport; the image source / observer side takes the master modport.
interface pixel_line_capture_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned FRAME_W = 4
);
  logic               HSYNC;
  logic               VSYNC;
  logic [15:0]        Pixel_DATA;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [15:0]        wr_data;
  logic               line_done;
  logic [31:0]        line_sum;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;
  logic [15:0]        row;
  logic               err_short;
  logic               err_long;
  logic               frame_abort;

  modport master (
    output HSYNC, VSYNC, Pixel_DATA,
    input  wr_en, wr_addr, wr_data, line_done, line_sum, frame_done, frame_cnt,
           row, err_short, err_long, frame_abort
  );

  modport slave (
    input  HSYNC, VSYNC, Pixel_DATA,
    output wr_en, wr_addr, wr_data, line_done, line_sum, frame_done, frame_cnt,
           row, err_short, err_long, frame_abort
  );
endinterface

// File: rtl/pixel_line_capture.sv
// pixel_line_capture: receive end of an HSYNC/VSYNC raster interface.
// Pixels sampled while HSYNC is high are written to an external frame buffer
// at row*IMG_WIDTH+col. Each line is length-checked, summed, and line/frame
// completion is flagged. VSYNC aborts the current frame.
// Ports:
//   PCLK   - pixel clock, all logic on posedge
//   RST    - asynchronous reset, active low
//   io_pix - raster inputs and frame-buffer/status outputs (slave side);
//            every output is registered
module pixel_line_capture #(
  parameter int unsigned IMG_WIDTH  = 8192,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FRAME_W    = 4
) (
  input logic                  PCLK,
  input logic                  RST,
  pixel_line_capture_if.slave  io_pix
);

  localparam int unsigned     ColW    = $clog2(IMG_WIDTH + 1);
  localparam logic [ColW-1:0] ColMax  = ColW'(IMG_WIDTH);
  localparam logic [15:0]     RowLast = 16'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StLine, StOver} state_e;

  state_e             r_state, w_state_nxt;
  logic [ColW-1:0]    r_col, w_col_nxt;
  logic [31:0]        r_sum, w_sum_nxt;
  logic [15:0]        r_row, w_row_nxt;
  logic [FRAME_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic               r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]  r_wr_addr, w_wr_addr_nxt;
  logic [15:0]        r_wr_data, w_wr_data_nxt;
  logic               r_line_done, w_line_done_nxt;
  logic [31:0]        r_line_sum, w_line_sum_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_err_short, w_err_short_nxt;
  logic               r_err_long, w_err_long_nxt;
  logic               r_frame_abort, w_frame_abort_nxt;

  logic [31:0]        w_addr_full;

  // col is 0 in IDLE, so one address expression serves both IDLE and LINE.
  assign w_addr_full = (32'(r_row) * IMG_WIDTH) + 32'(r_col);

  always_comb begin
    w_state_nxt       = r_state;
    w_col_nxt         = r_col;
    w_sum_nxt         = r_sum;
    w_row_nxt         = r_row;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = '0;
    w_wr_data_nxt     = '0;
    w_line_done_nxt   = 1'b0;
    w_line_sum_nxt    = '0;
    w_frame_done_nxt  = 1'b0;
    w_err_short_nxt   = 1'b0;
    w_err_long_nxt    = 1'b0;
    w_frame_abort_nxt = 1'b0;

    if (io_pix.VSYNC) begin
      // Resync overrides everything, including a coincident line end.
      w_frame_abort_nxt = (r_state != StIdle) || (r_row != 16'd0);
      w_state_nxt       = StIdle;
      w_col_nxt         = '0;
      w_sum_nxt         = '0;
      w_row_nxt         = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_pix.HSYNC) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_addr_full[ADDR_W-1:0];
            w_wr_data_nxt = io_pix.Pixel_DATA;
            w_col_nxt     = ColW'(1);
            w_sum_nxt     = 32'(io_pix.Pixel_DATA);
            w_state_nxt   = StLine;
          end
        end
        StLine: begin
          if (io_pix.HSYNC) begin
            if (r_col < ColMax) begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = w_addr_full[ADDR_W-1:0];
              w_wr_data_nxt = io_pix.Pixel_DATA;
              w_col_nxt     = r_col + ColW'(1);
              w_sum_nxt     = r_sum + 32'(io_pix.Pixel_DATA);
            end else begin
              w_state_nxt = StOver;
            end
          end else begin
            if (r_col == ColMax) begin
              w_line_done_nxt = 1'b1;
              w_line_sum_nxt  = r_sum;
              if (r_row == RowLast) begin
                w_frame_done_nxt = 1'b1;
                w_row_nxt        = '0;
                w_frame_cnt_nxt  = r_frame_cnt + FRAME_W'(1);
              end else begin
                w_row_nxt = r_row + 16'd1;
              end
            end else begin
              // Row is kept so the next line overwrites the short one.
              w_err_short_nxt = 1'b1;
            end
            w_col_nxt   = '0;
            w_state_nxt = StIdle;
          end
        end
        StOver: begin
          if (!io_pix.HSYNC) begin
            w_err_long_nxt = 1'b1;
            w_col_nxt      = '0;
            w_state_nxt    = StIdle;
          end
        end
        default: begin
          w_col_nxt   = '0;
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      r_state       <= StIdle;
      r_col         <= '0;
      r_sum         <= '0;
      r_row         <= '0;
      r_frame_cnt   <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_line_done   <= 1'b0;
      r_line_sum    <= '0;
      r_frame_done  <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_sum         <= w_sum_nxt;
      r_row         <= w_row_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_line_done   <= w_line_done_nxt;
      r_line_sum    <= w_line_sum_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_err_short   <= w_err_short_nxt;
      r_err_long    <= w_err_long_nxt;
      r_frame_abort <= w_frame_abort_nxt;
    end
  end

  assign io_pix.wr_en       = r_wr_en;
  assign io_pix.wr_addr     = r_wr_addr;
  assign io_pix.wr_data     = r_wr_data;
  assign io_pix.line_done   = r_line_done;
  assign io_pix.line_sum    = r_line_sum;
  assign io_pix.frame_done  = r_frame_done;
  assign io_pix.frame_cnt   = r_frame_cnt;
  assign io_pix.row         = r_row;
  assign io_pix.err_short   = r_err_short;
  assign io_pix.err_long    = r_err_long;
  assign io_pix.frame_abort = r_frame_abort;

endmodule

// File: tb/tb_pixel_line_capture.sv
// Directed self-checking bench for pixel_line_capture with a 16x4 frame.
// Inputs change 1 time unit after each rising PCLK edge; outputs are checked
// at that same point, so they reflect the inputs sampled at the edge just taken.
module tb_pixel_line_capture;
  localparam int unsigned W       = 16;
  localparam int unsigned H       = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned FRAME_W = 4;

  logic PCLK;
  logic RST;
  int   n_assert;
  int   n_fail;

  pixel_line_capture_if #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) pix ();

  pixel_line_capture #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (ADDR_W),
    .FRAME_W   (FRAME_W)
  ) dut (
    .PCLK  (PCLK),
    .RST   (RST),
    .io_pix(pix)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, required end before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle of write/pulse outputs; address only meaningful on a write.
  task automatic chk_cyc(input string tag, input logic en, input int addr, input int data,
                         input logic ld, input logic fd, input logic es, input logic el,
                         input logic fa);
    chk({tag, ".wr_en"}, 32'(pix.wr_en), 32'(en));
    if (en) chk({tag, ".wr_addr"}, 32'(pix.wr_addr), 32'(addr));
    chk({tag, ".wr_data"}, 32'(pix.wr_data), 32'(data));
    chk({tag, ".line_done"}, 32'(pix.line_done), 32'(ld));
    chk({tag, ".frame_done"}, 32'(pix.frame_done), 32'(fd));
    chk({tag, ".err_short"}, 32'(pix.err_short), 32'(es));
    chk({tag, ".err_long"}, 32'(pix.err_long), 32'(el));
    chk({tag, ".frame_abort"}, 32'(pix.frame_abort), 32'(fa));
  endtask

  task automatic chk_zero(input string tag);
    chk_cyc(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".wr_addr"}, 32'(pix.wr_addr), 32'd0);
    chk({tag, ".line_sum"}, pix.line_sum, 32'd0);
    chk({tag, ".frame_cnt"}, 32'(pix.frame_cnt), 32'd0);
    chk({tag, ".row"}, 32'(pix.row), 32'd0);
  endtask

  // n pixels of constant value d on row r; only the first W are written.
  task automatic line_const(input string tag, input int r, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      pix.HSYNC      = 1'b1;
      pix.Pixel_DATA = d;
      tick();
      if (i < int'(W)) chk_cyc(tag, 1'b1, r * int'(W) + i, int'(d), 0, 0, 0, 0, 0);
      else             chk_cyc(tag, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // One low HSYNC cycle closing a line.
  task automatic gap(input string tag, input logic ld, input logic [31:0] sum, input logic fd,
                     input logic es, input logic el, input int exp_row);
    pix.HSYNC      = 1'b0;
    pix.Pixel_DATA = 16'h0;
    tick();
    chk_cyc(tag, 1'b0, 0, 0, ld, fd, es, el, 1'b0);
    if (ld) chk({tag, ".line_sum"}, pix.line_sum, sum);
    chk({tag, ".row"}, 32'(pix.row), 32'(exp_row));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    RST            = 1'b0;
    pix.HSYNC      = 1'b0;
    pix.VSYNC      = 1'b0;
    pix.Pixel_DATA = 16'h0;

    // 1: reset held with HSYNC toggling, then release
    for (int i = 0; i < 4; i++) begin
      pix.HSYNC      = ~pix.HSYNC;
      pix.Pixel_DATA = 16'(i + 1);
      tick();
      chk_zero("reset_hold");
    end
    pix.HSYNC = 1'b0;
    RST       = 1'b1;
    tick();
    chk_zero("reset_release");
    tick();
    chk_zero("idle_no_hsync");

    // 2: good line, data 0..15
    for (int i = 0; i < int'(W); i++) begin
      pix.HSYNC      = 1'b1;
      pix.Pixel_DATA = 16'(i);
      tick();
      chk_cyc("good_px", 1'b1, i, i, 0, 0, 0, 0, 0);
    end
    gap("good_end", 1'b1, 32'd120, 1'b0, 1'b0, 1'b0, 1);
    pix.HSYNC = 1'b0;
    tick();
    chk_cyc("good_after", 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // VSYNC with row 1: abort pulse; then VSYNC idle on row 0: no pulse
    pix.VSYNC = 1'b1;
    tick();
    chk_cyc("vs_row1", 1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    chk("vs_row1.row", 32'(pix.row), 32'd0);
    tick();
    chk_cyc("vs_held", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    pix.VSYNC = 1'b0;
    tick();
    chk_cyc("vs_release", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

    // 3: full frame, 4 lines of 1s with single-cycle gaps
    for (int r = 0; r < int'(H); r++) begin
      line_const("frame_px", r, 16'd1, int'(W));
      gap("frame_end", 1'b1, 32'd16, (r == int'(H) - 1), 1'b0, 1'b0, (r + 1) % int'(H));
    end
    chk("frame.frame_cnt", 32'(pix.frame_cnt), 32'd1);

    // 4: short line on row 1 then a good line overwriting it
    line_const("row0_px", 0, 16'd0, int'(W));
    gap("row0_end", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    line_const("short_px", 1, 16'd7, 10);
    gap("short_end", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1);
    line_const("redo_px", 1, 16'd2, int'(W));
    gap("redo_end", 1'b1, 32'd32, 1'b0, 1'b0, 1'b0, 2);

    // 5: back to row 0, then a 20-pixel line
    pix.VSYNC = 1'b1;
    tick();
    chk_cyc("vs_row2", 1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    pix.VSYNC = 1'b0;
    line_const("long_px", 0, 16'd3, 20);
    gap("long_end", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
    tick();
    chk_cyc("long_after", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    chk("long.frame_cnt", 32'(pix.frame_cnt), 32'd1);

    // 6: VSYNC at pixel 5 of row 2
    line_const("r0_px", 0, 16'd1, int'(W));
    gap("r0_end", 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 1);
    line_const("r1_px", 1, 16'd1, int'(W));
    gap("r1_end", 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 2);
    line_const("r2_px", 2, 16'd5, 5);
    pix.VSYNC      = 1'b1;
    pix.HSYNC      = 1'b1;
    pix.Pixel_DATA = 16'd9;
    tick();
    chk_cyc("vs_mid", 1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    chk("vs_mid.row", 32'(pix.row), 32'd0);
    chk("vs_mid.frame_cnt", 32'(pix.frame_cnt), 32'd1);
    pix.VSYNC = 1'b0;
    pix.HSYNC = 1'b0;
    tick();
    chk_cyc("vs_mid_after", 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-line: everything cleared, no pulses afterwards
    line_const("rst_px", 0, 16'd4, 5);
    RST = 1'b0;
    #1;
    chk_zero("rst_async");
    pix.HSYNC = 1'b0;
    tick();
    chk_zero("rst_mid_hold");
    RST = 1'b1;
    tick();
    chk_zero("rst_mid_release");
    line_const("post_rst_px", 0, 16'd6, int'(W));
    gap("post_rst_end", 1'b1, 32'd96, 1'b0, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
